// File: rtl/data_mem_clr.sv
// data_mem_clr: DATA_W x 2**ADDR_W data memory with a built-in clear sequencer.
// The storage array has no reset. After reset, or on clearReq, the block zeroes
// one word per cycle and holds busy high until the wipe is complete.
// Optional feature: define DATA_MEM_CLR_RDREG_EN for a registered read port
// (1-cycle read latency). When it is undefined, the read port is combinational.
module data_mem_clr #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clearReq,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataInput,
  output logic [DATA_W-1:0] dataOutput,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] clr_addr_r;
  logic [ADDR_W-1:0] clr_addr_s;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_data_s;

  logic [DATA_W-1:0] core_r [DEPTH];

  // State and clear-address registers; reset restarts the wipe from word 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_CLEAR;
      clr_addr_r <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= state_s;
      clr_addr_r <= clr_addr_s;
    end
  end

  // Next-state logic and array write-port steering (sequencer owns the port in CLEAR).
  always_comb begin
    state_s    = state_r;
    clr_addr_s = clr_addr_r;
    mem_we_s   = 1'b0;
    mem_addr_s = address;
    mem_data_s = dataInput;
    case (state_r)
      ST_CLEAR: begin
        // User writeEn and clearReq are ignored here and not queued.
        mem_we_s   = 1'b1;
        mem_addr_s = clr_addr_r;
        mem_data_s = {DATA_W{1'b0}};
        if (clr_addr_r == {ADDR_W{1'b1}}) begin
          state_s = ST_IDLE;
        end else begin
          clr_addr_s = clr_addr_r + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        // A write coinciding with clearReq still lands; the wipe zeroes it later.
        mem_we_s = writeEn;
        if (clearReq) begin
          state_s    = ST_CLEAR;
          clr_addr_s = {ADDR_W{1'b0}};
        end else begin
          state_s    = ST_IDLE;
          clr_addr_s = clr_addr_r;
        end
      end
      default: begin
        state_s    = ST_CLEAR;
        clr_addr_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Storage array write; deliberately unreset, the sequencer wipes it instead.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      core_r[mem_addr_s] <= mem_data_s;
    end
  end

  // busy is decoded straight from the state register, so it cannot glitch.
  assign busy = (state_r == ST_CLEAR);

`ifdef DATA_MEM_CLR_RDREG_EN
  logic [DATA_W-1:0] rd_data_r;

  // Registered read port: the value sampled before the edge, so same-address RDW returns old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (busy) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else begin
      rd_data_r <= core_r[address];
    end
  end

  assign dataOutput = rd_data_r;
`else
  // Combinational read port, masked to zero while the array is being wiped.
  always_comb begin
    if (busy) begin
      dataOutput = {DATA_W{1'b0}};
    end else begin
      dataOutput = core_r[address];
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_clr.sv
// tb_data_mem_clr: randomized and directed stimulus for data_mem_clr (DATA_W=8,
// ADDR_W=4), checked against a behavioural model. The model treats a wipe as an
// instant zeroing of the whole array plus a busy countdown of DEPTH edges. This is
// observably equivalent, because reads are masked and writes are blocked while busy.
// Define DATA_MEM_CLR_RDREG_EN to check the registered-read build.
module tb_data_mem_clr;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          clearReq  = 1'b0;
  logic          writeEn   = 1'b0;
  logic [AW-1:0] address   = '0;
  logic [DW-1:0] dataInput = '0;
  logic [DW-1:0] dataOutput;
  logic          busy;

  data_mem_clr #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .clearReq   (clearReq),
    .writeEn    (writeEn),
    .address    (address),
    .dataInput  (dataInput),
    .dataOutput (dataOutput),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mdl_mem [DEPTH];
  int            mdl_busy_left;
  logic [DW-1:0] mdl_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
    return (mdl_busy_left > 0) ? 8'h00 : mdl_mem[a];
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
    mdl_busy_left = DEPTH;
    mdl_rd        = 8'h00;
  endtask

  // One clock: drive the inputs, check the outputs before the edge, then advance the model at the edge.
  task automatic step(input logic we, input logic clr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input string tag);
    @(negedge clk);
    writeEn   = we;
    clearReq  = clr;
    address   = a;
    dataInput = d;
    #1;
    chk({tag, "_busy"}, 32'(busy), 32'(mdl_busy_left > 0));
`ifdef DATA_MEM_CLR_RDREG_EN
    chk({tag, "_dout"}, 32'(dataOutput), 32'(mdl_rd));
`else
    chk({tag, "_dout"}, 32'(dataOutput), 32'(mdl_read(a)));
`endif
    @(posedge clk);
    if (reset) begin
      mdl_rd = mdl_read(a);
      if (mdl_busy_left > 0) begin
        mdl_busy_left--;
      end else begin
        if (we) mdl_mem[a] = d;
        if (clr) begin
          for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
          mdl_busy_left = DEPTH;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mdl_reset();
    repeat (2) step(1'b1, 1'b1, 4'($urandom), 8'($urandom), "in_reset");
    #2;
    reset = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom), 8'($urandom), tag);
  endtask

  // Read every address; one trailing cycle lets the registered build show the last word.
  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 4'(i), 8'h00, tag);
    step(1'b0, 1'b0, 4'h0, 8'h00, tag);
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 4'(i), v, "fill");
  endtask

  initial begin
    mdl_reset();

    // Reset release, then the 16-cycle wipe and a read-back of zeros.
    do_reset();
    idle_cycles(DEPTH, "rst_wipe");
    step(1'b0, 1'b0, 4'h0, 8'h00, "rst_done");
    read_all("rd_init");

    // Write/read, including a same-address read-during-write.
    step(1'b1, 1'b0, 4'd3,  8'hA5, "wr3");
    step(1'b1, 1'b0, 4'd15, 8'h5A, "wr15");
    step(1'b1, 1'b0, 4'd15, 8'h11, "rdw15");
    step(1'b1, 1'b0, 4'd15, 8'h5A, "rdw15b");
    read_all("rd_wr");

    // Clear request over a full array.
    fill(8'hFF);
    read_all("rd_ff");
    step(1'b0, 1'b1, 4'd7, 8'h00, "clrreq");
    idle_cycles(DEPTH, "clr_wipe");
    read_all("rd_clr");

    // Blocked traffic during CLEAR.
    step(1'b0, 1'b1, 4'd0, 8'h00, "clr2");
    step(1'b1, 1'b0, 4'd5, 8'h77, "blk_wr");
    step(1'b1, 1'b1, 4'd5, 8'h77, "blk_both");
    idle_cycles(DEPTH - 2, "blk_wipe");
    step(1'b0, 1'b0, 4'd5, 8'h00, "blk_rd5");
    step(1'b0, 1'b0, 4'd5, 8'h00, "blk_rd5b");

    // Simultaneous write and clear request.
    step(1'b1, 1'b1, 4'd2, 8'h3C, "simul");
    idle_cycles(DEPTH, "simul_wipe");
    step(1'b0, 1'b0, 4'd2, 8'h00, "simul_rd2");
    step(1'b0, 1'b0, 4'd2, 8'h00, "simul_rd2b");

    // Mid-clear reset at clrAddr = 9 over a prefilled array.
    fill(8'hFF);
    step(1'b0, 1'b1, 4'd0, 8'h00, "mid_clr");
    idle_cycles(9, "mid_pre");
    do_reset();
    idle_cycles(DEPTH, "mid_wipe");
    read_all("rd_mid");

    // Randomized traffic with occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0),
           4'($urandom), 8'($urandom), "rand");
    end
    read_all("rd_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
